hs_sync_rx_multi: RTL and testbench

- Parametrised, multi-channel receive side of a 4-phase req/ack handshake. It replaces the fixed two-flop enable/ready synchronizer pair.
- Each channel takes an asynchronous request and its data bus from a foreign domain and synchronizes the request through STAGES flops.
- Data is captured and presented to local logic with valid/ready. The 4-phase ack is returned only after local consumption.
- Adds timeout and protocol-violation detection. Sits in the pclk domain of the SPI/APB bridge.

---
 rtl/hs_sync_rx_multi_if.sv | 30 +++
 rtl/hs_sync_rx_multi.sv | 145 ++++++++++++++
 tb/tb_hs_sync_rx_multi.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_sync_rx_multi_if.sv
// Bundle of per-channel handshake, data and status signals between a foreign
// request source, the hs_sync_rx_multi receiver and its local consumer.
interface hs_sync_rx_multi_if #(
  parameter int CH = 2,
  parameter int DW = 8
);
  logic [CH-1:0]    async_req;
  logic [CH*DW-1:0] async_data;
  logic [CH-1:0]    ack;
  logic [CH-1:0]    req_sync;
  logic [CH-1:0]    req_rise;
  logic [CH*DW-1:0] data_out;
  logic [CH-1:0]    data_valid;
  logic [CH-1:0]    data_ready;
  logic [CH-1:0]    to_err;
  logic [CH-1:0]    proto_err;
  logic [CH-1:0]    err_clr;

  // Receiver side.
  modport slave (
    input  async_req, async_data, data_ready, err_clr,
    output ack, req_sync, req_rise, data_out, data_valid, to_err, proto_err
  );

  // Source plus local consumer side.
  modport master (
    output async_req, async_data, data_ready, err_clr,
    input  ack, req_sync, req_rise, data_out, data_valid, to_err, proto_err
  );
endinterface

// File: rtl/hs_sync_rx_multi.sv
// Multi-channel receive side of a 4-phase req/ack handshake: synchronizes each
// request, captures its data, hands it over with valid/ready and acks on consumption.
module hs_sync_rx_multi #(
  parameter int CH      = 2,
  parameter int DW      = 8,
  parameter int STAGES  = 2,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              pclk,
  input  logic              preset_n,
  hs_sync_rx_multi_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_e;

  // TIMEOUT of 0 gives a zero limit, which the saturation test never lets the counter leave.
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

  if (TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
    $error("hs_sync_rx_multi: TIMEOUT does not fit in TO_W bits");
  end
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("hs_sync_rx_multi: STAGES must be 2..4");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [STAGES-1:0] sync_q;
    logic              req_s;
    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic              dv_q, dv_d;
    logic              rise_q, rise_d;
    logic              to_q, to_d;
    logic              pe_q, pe_d;
    logic [DW-1:0]     data_q, data_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              to_set_s, pe_set_s;

    assign req_s = sync_q[STAGES-1];

    // Request synchronizer chain; data is never synchronized, only captured.
    always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[STAGES-2:0], bus.async_req[i]};
      end
    end

    // Channel FSM and registered outputs.
    always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
        state_q <= IDLE;
        ack_q   <= 1'b0;
        dv_q    <= 1'b0;
        rise_q  <= 1'b0;
        to_q    <= 1'b0;
        pe_q    <= 1'b0;
        data_q  <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        ack_q   <= ack_d;
        dv_q    <= dv_d;
        rise_q  <= rise_d;
        to_q    <= to_d;
        pe_q    <= pe_d;
        data_q  <= data_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state logic; data_ready outranks a withdrawn request in HOLD.
    always_comb begin
      state_d  = state_q;
      ack_d    = ack_q;
      dv_d     = dv_q;
      rise_d   = 1'b0;
      data_d   = data_q;
      cnt_d    = cnt_q;
      to_set_s = 1'b0;
      pe_set_s = 1'b0;
      case (state_q)
        IDLE: begin
          ack_d = 1'b0;
          if (req_s) begin
            state_d = HOLD;
            data_d  = bus.async_data[i*DW +: DW];
            dv_d    = 1'b1;
            rise_d  = 1'b1;
          end else begin
            dv_d = 1'b0;
          end
        end
        HOLD: begin
          if (bus.data_ready[i]) begin
            state_d = ACK;
            dv_d    = 1'b0;
            ack_d   = 1'b1;
            cnt_d   = '0;
          end else if (!req_s) begin
            state_d  = IDLE;
            dv_d     = 1'b0;
            pe_set_s = 1'b1;
          end else begin
            dv_d = 1'b1;
          end
        end
        ACK: begin
          if (!req_s) begin
            state_d = IDLE;
            ack_d   = 1'b0;
          end else if (cnt_q != TO_LIM) begin
            cnt_d    = cnt_q + CNT_ONE;
            to_set_s = ((cnt_q + CNT_ONE) == TO_LIM);
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          ack_d   = 1'b0;
          dv_d    = 1'b0;
        end
      endcase
      to_d = to_set_s | (to_q & ~bus.err_clr[i]);
      pe_d = pe_set_s | (pe_q & ~bus.err_clr[i]);
    end

    assign bus.ack[i]                  = ack_q;
    assign bus.req_sync[i]             = req_s;
    assign bus.req_rise[i]             = rise_q;
    assign bus.data_valid[i]           = dv_q;
    assign bus.to_err[i]               = to_q;
    assign bus.proto_err[i]            = pe_q;
    assign bus.data_out[i*DW +: DW]    = data_q;
  end

endmodule

// File: tb/tb_hs_sync_rx_multi.sv
// Self-checking bench for hs_sync_rx_multi (CH=2, STAGES=2, TIMEOUT=5); inputs
// are driven and outputs sampled on the falling edge of pclk.
module tb_hs_sync_rx_multi;
  localparam int CH      = 2;
  localparam int DW      = 8;
  localparam int STAGES  = 2;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 5;

  logic pclk = 1'b0;
  logic preset_n;
  int   total = 0;
  int   bad   = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  always #5 pclk = ~pclk;

  hs_sync_rx_multi_if #(.CH(CH), .DW(DW)) bus ();

  hs_sync_rx_multi #(
    .CH(CH), .DW(DW), .STAGES(STAGES), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk),
    .preset_n(preset_n),
    .bus(bus.slave)
  );

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic test_reset();
    preset_n        = 1'b0;
    bus.async_req   = 2'b11;
    bus.async_data  = 16'hFFFF;
    bus.data_ready  = 2'b11;
    bus.err_clr     = 2'b00;
    repeat (3) tick();
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL rst_ack: got %b want 00", bus.ack); end
    total++; if (bus.data_valid !== 2'b00) begin bad++; $display("FAIL rst_valid: got %b want 00", bus.data_valid); end
    total++; if (bus.req_sync !== 2'b00) begin bad++; $display("FAIL rst_req_sync: got %b want 00", bus.req_sync); end
    total++; if (bus.req_rise !== 2'b00) begin bad++; $display("FAIL rst_req_rise: got %b want 00", bus.req_rise); end
    total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h want 0000", bus.data_out); end
    total++; if (bus.to_err !== 2'b00) begin bad++; $display("FAIL rst_to_err: got %b want 00", bus.to_err); end
    total++; if (bus.proto_err !== 2'b00) begin bad++; $display("FAIL rst_proto_err: got %b want 00", bus.proto_err); end
    bus.async_req  = 2'b00;
    bus.async_data = 16'h0000;
    bus.data_ready = 2'b00;
    repeat (2) tick();
    preset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp;
    bus.async_data[7:0] = 8'hA5;
    bus.data_ready      = 2'b01;
    bus.async_req[0]    = 1'b1;
    exp_q0.push_back(8'hA5);
    tick();
    total++; if (bus.req_sync !== 2'b00) begin bad++; $display("FAIL basic_sync_e1: got %b want 00", bus.req_sync); end
    tick();
    total++; if (bus.req_sync !== 2'b01) begin bad++; $display("FAIL basic_sync_e2: got %b want 01", bus.req_sync); end
    total++; if (bus.data_valid !== 2'b00) begin bad++; $display("FAIL basic_valid_early: got %b want 00", bus.data_valid); end
    tick();
    total++; if (bus.req_rise !== 2'b01) begin bad++; $display("FAIL basic_rise: got %b want 01", bus.req_rise); end
    total++; if (bus.data_valid !== 2'b01) begin bad++; $display("FAIL basic_valid: got %b want 01", bus.data_valid); end
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL basic_ack_early: got %b want 00", bus.ack); end
    total++;
    if (exp_q0.size() == 0) begin bad++; $display("FAIL basic_sb: got empty queue want entry"); end
    else begin
      exp = exp_q0.pop_front();
      if (bus.data_out[7:0] !== exp) begin bad++; $display("FAIL basic_data: got %h want %h", bus.data_out[7:0], exp); end
    end
    tick();
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL basic_ack: got %b want 01", bus.ack); end
    total++; if (bus.data_valid !== 2'b00) begin bad++; $display("FAIL basic_valid_drop: got %b want 00", bus.data_valid); end
    total++; if (bus.req_rise !== 2'b00) begin bad++; $display("FAIL basic_rise_pulse: got %b want 00", bus.req_rise); end
    bus.async_req[0] = 1'b0;
    repeat (2) tick();
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL basic_ack_hold: got %b want 01", bus.ack); end
    tick();
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL basic_ack_fall: got %b want 00", bus.ack); end
    total++; if (bus.data_out[15:8] !== 8'h00) begin bad++; $display("FAIL basic_ch1_data: got %h want 00", bus.data_out[15:8]); end
    bus.data_ready = 2'b00;
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp;
    bus.async_data[7:0] = 8'h5A;
    bus.async_req[0]    = 1'b1;
    exp_q0.push_back(8'h5A);
    repeat (3) tick();
    total++;
    if (exp_q0.size() == 0) begin bad++; $display("FAIL bp_sb: got empty queue want entry"); end
    else begin
      exp = exp_q0.pop_front();
      if (bus.data_out[7:0] !== exp) begin bad++; $display("FAIL bp_data: got %h want %h", bus.data_out[7:0], exp); end
    end
    for (int c = 0; c < 10; c++) begin
      total++; if (bus.data_valid !== 2'b01) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 01", c, bus.data_valid); end
      total++; if (bus.data_out[7:0] !== 8'h5A) begin bad++; $display("FAIL bp_stable[%0d]: got %h want 5a", c, bus.data_out[7:0]); end
      total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL bp_ack[%0d]: got %b want 00", c, bus.ack); end
      tick();
    end
    bus.data_ready = 2'b01;
    tick();
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL bp_ack_rise: got %b want 01", bus.ack); end
    total++; if (bus.data_valid !== 2'b00) begin bad++; $display("FAIL bp_valid_drop: got %b want 00", bus.data_valid); end
    bus.async_req[0] = 1'b0;
    bus.data_ready   = 2'b00;
    repeat (3) tick();
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL bp_ack_fall: got %b want 00", bus.ack); end
    repeat (2) tick();
  endtask

  task automatic test_proto();
    logic [DW-1:0] exp;
    bus.async_data[7:0] = 8'h77;
    bus.async_req[0]    = 1'b1;
    exp_q0.push_back(8'h77);
    repeat (3) tick();
    total++;
    if (exp_q0.size() == 0) begin bad++; $display("FAIL pe_sb: got empty queue want entry"); end
    else begin
      exp = exp_q0.pop_front();
      if (bus.data_out[7:0] !== exp) begin bad++; $display("FAIL pe_data: got %h want %h", bus.data_out[7:0], exp); end
    end
    bus.async_req[0] = 1'b0;
    tick();
    total++; if (bus.data_valid !== 2'b01) begin bad++; $display("FAIL pe_valid_m1: got %b want 01", bus.data_valid); end
    tick();
    total++; if (bus.proto_err !== 2'b00) begin bad++; $display("FAIL pe_early: got %b want 00", bus.proto_err); end
    bus.err_clr = 2'b01;
    tick();
    total++; if (bus.proto_err !== 2'b01) begin bad++; $display("FAIL pe_set_wins: got %b want 01", bus.proto_err); end
    total++; if (bus.data_valid !== 2'b00) begin bad++; $display("FAIL pe_valid_drop: got %b want 00", bus.data_valid); end
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL pe_no_ack: got %b want 00", bus.ack); end
    tick();
    total++; if (bus.proto_err !== 2'b00) begin bad++; $display("FAIL pe_clear: got %b want 00", bus.proto_err); end
    bus.err_clr = 2'b00;
    tick();
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL pe_no_ack_late: got %b want 00", bus.ack); end
    tick();
  endtask

  task automatic test_timeout();
    logic [DW-1:0] exp;
    bus.async_data[7:0] = 8'h11;
    bus.data_ready      = 2'b01;
    bus.async_req[0]    = 1'b1;
    exp_q0.push_back(8'h11);
    repeat (3) tick();
    total++;
    if (exp_q0.size() == 0) begin bad++; $display("FAIL to_sb: got empty queue want entry"); end
    else begin
      exp = exp_q0.pop_front();
      if (bus.data_out[7:0] !== exp) begin bad++; $display("FAIL to_data: got %h want %h", bus.data_out[7:0], exp); end
    end
    tick();
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL to_ack: got %b want 01", bus.ack); end
    bus.data_ready = 2'b00;
    repeat (4) tick();
    total++; if (bus.to_err !== 2'b00) begin bad++; $display("FAIL to_early: got %b want 00", bus.to_err); end
    tick();
    total++; if (bus.to_err !== 2'b01) begin bad++; $display("FAIL to_set: got %b want 01", bus.to_err); end
    repeat (3) tick();
    total++; if (bus.to_err !== 2'b01) begin bad++; $display("FAIL to_sticky: got %b want 01", bus.to_err); end
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL to_ack_held: got %b want 01", bus.ack); end
    bus.async_req[0] = 1'b0;
    repeat (3) tick();
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL to_ack_fall: got %b want 00", bus.ack); end
    bus.err_clr = 2'b01;
    tick();
    total++; if (bus.to_err !== 2'b00) begin bad++; $display("FAIL to_clear: got %b want 00", bus.to_err); end
    bus.err_clr = 2'b00;
    tick();
  endtask

  task automatic test_both();
    logic [DW-1:0] exp;
    bus.async_data = 16'hC33C;
    bus.async_req  = 2'b11;
    exp_q0.push_back(8'h3C);
    exp_q1.push_back(8'hC3);
    repeat (3) tick();
    total++; if (bus.data_valid !== 2'b11) begin bad++; $display("FAIL both_valid: got %b want 11", bus.data_valid); end
    total++; if (bus.req_rise !== 2'b11) begin bad++; $display("FAIL both_rise: got %b want 11", bus.req_rise); end
    total++;
    if (exp_q0.size() == 0) begin bad++; $display("FAIL both_sb0: got empty queue want entry"); end
    else begin
      exp = exp_q0.pop_front();
      if (bus.data_out[7:0] !== exp) begin bad++; $display("FAIL both_data0: got %h want %h", bus.data_out[7:0], exp); end
    end
    total++;
    if (exp_q1.size() == 0) begin bad++; $display("FAIL both_sb1: got empty queue want entry"); end
    else begin
      exp = exp_q1.pop_front();
      if (bus.data_out[15:8] !== exp) begin bad++; $display("FAIL both_data1: got %h want %h", bus.data_out[15:8], exp); end
    end
    bus.data_ready = 2'b10;
    tick();
    total++; if (bus.ack !== 2'b10) begin bad++; $display("FAIL both_ack1: got %b want 10", bus.ack); end
    total++; if (bus.data_valid !== 2'b01) begin bad++; $display("FAIL both_valid0_held: got %b want 01", bus.data_valid); end
    total++; if (bus.data_out[7:0] !== 8'h3C) begin bad++; $display("FAIL both_data0_stable: got %h want 3c", bus.data_out[7:0]); end
    bus.async_req[1] = 1'b0;
    tick();
    bus.data_ready = 2'b01;
    tick();
    total++; if (bus.ack !== 2'b11) begin bad++; $display("FAIL both_ack_both: got %b want 11", bus.ack); end
    total++; if (bus.data_valid !== 2'b00) begin bad++; $display("FAIL both_valid_none: got %b want 00", bus.data_valid); end
    bus.async_req[0] = 1'b0;
    bus.data_ready   = 2'b00;
    tick();
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL both_ack1_fall: got %b want 01", bus.ack); end
    repeat (2) tick();
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL both_ack0_fall: got %b want 00", bus.ack); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp;
    bus.async_data[7:0] = 8'h99;
    bus.data_ready      = 2'b01;
    bus.async_req[0]    = 1'b1;
    exp_q0.push_back(8'h99);
    repeat (3) tick();
    total++;
    if (exp_q0.size() == 0) begin bad++; $display("FAIL rm_sb: got empty queue want entry"); end
    else begin
      exp = exp_q0.pop_front();
      if (bus.data_out[7:0] !== exp) begin bad++; $display("FAIL rm_data: got %h want %h", bus.data_out[7:0], exp); end
    end
    tick();
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL rm_ack: got %b want 01", bus.ack); end
    repeat (5) tick();
    total++; if (bus.to_err !== 2'b01) begin bad++; $display("FAIL rm_to_pre: got %b want 01", bus.to_err); end
    #2 preset_n = 1'b0;
    #1;
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL rm_ack_rst: got %b want 00", bus.ack); end
    total++; if (bus.data_valid !== 2'b00) begin bad++; $display("FAIL rm_valid_rst: got %b want 00", bus.data_valid); end
    total++; if (bus.to_err !== 2'b00) begin bad++; $display("FAIL rm_to_rst: got %b want 00", bus.to_err); end
    total++; if (bus.req_sync !== 2'b00) begin bad++; $display("FAIL rm_sync_rst: got %b want 00", bus.req_sync); end
    total++; if (bus.data_out !== 16'h0000) begin bad++; $display("FAIL rm_data_rst: got %h want 0000", bus.data_out); end
    bus.async_req  = 2'b00;
    bus.data_ready = 2'b00;
    repeat (2) tick();
    preset_n = 1'b1;
    tick();
    bus.async_data[7:0] = 8'h42;
    bus.data_ready      = 2'b01;
    bus.async_req[0]    = 1'b1;
    exp_q0.push_back(8'h42);
    repeat (3) tick();
    total++; if (bus.data_valid !== 2'b01) begin bad++; $display("FAIL rm2_valid: got %b want 01", bus.data_valid); end
    total++;
    if (exp_q0.size() == 0) begin bad++; $display("FAIL rm2_sb: got empty queue want entry"); end
    else begin
      exp = exp_q0.pop_front();
      if (bus.data_out[7:0] !== exp) begin bad++; $display("FAIL rm2_data: got %h want %h", bus.data_out[7:0], exp); end
    end
    tick();
    total++; if (bus.ack !== 2'b01) begin bad++; $display("FAIL rm2_ack: got %b want 01", bus.ack); end
    bus.async_req[0] = 1'b0;
    bus.data_ready   = 2'b00;
    repeat (3) tick();
    total++; if (bus.ack !== 2'b00) begin bad++; $display("FAIL rm2_ack_fall: got %b want 00", bus.ack); end
    tick();
  endtask

  initial begin
    preset_n       = 1'b0;
    bus.async_req  = 2'b00;
    bus.async_data = 16'h0000;
    bus.data_ready = 2'b00;
    bus.err_clr    = 2'b00;
    test_reset();
    test_basic();
    test_backpressure();
    test_proto();
    test_timeout();
    test_both();
    test_reset_mid();
    total++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d leftover entries want 0", exp_q0.size() + exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
